// File: rtl/vga_num_writer.sv
// Sequential binary-to-BCD digit writer feeding the VGA tile RAM write port.
// Optional VGA_NUM_LEAD_BLANK_EN: leading zero digits are written as BLANK_TILE.
module vga_num_writer #(
  parameter int NUM_W      = 16,
  parameter int DIGITS     = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int BASE_ADDR  = 17,
  parameter int TILE_BASE  = 'h0100,
  parameter int BLANK_TILE = 'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              start,
  input  logic [NUM_W-1:0]  nums,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dina
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(NUM_W + 1);
`ifdef VGA_NUM_LEAD_BLANK_EN
  localparam bit LEAD_BLANK = 1'b1;
`else
  localparam bit LEAD_BLANK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CONV, WRITE, FIN} state_t;

  state_t            state, state_nx;
  logic [BW-1:0]     bcd, bcd_nx, adj;
  logic [NUM_W-1:0]  shreg, shreg_nx;
  logic [CW-1:0]     bit_cnt, bit_nx;
  logic [3:0]        k, k_nx;
  logic              lead, lead_nx;
  logic              busy_nx, done_nx, ovf_nx, we_nx, ovf_bit;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] dina_nx;
  logic [3:0]        cur;
  int                sh;

  // add-3 correction per nibble, and the digit selected by the write counter
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    sh  = (int'(k) < DIGITS) ? 4 * (DIGITS - 1 - int'(k)) : 0;
    cur = 4'(bcd >> sh);
  end

  always_comb begin
    state_nx = state;
    bcd_nx   = bcd;
    shreg_nx = shreg;
    bit_nx   = bit_cnt;
    k_nx     = k;
    lead_nx  = lead;
    busy_nx  = busy;
    done_nx  = 1'b0;
    ovf_nx   = overflow;
    we_nx    = 1'b0;
    addr_nx  = addr;
    dina_nx  = dina;
    ovf_bit  = 1'b0;
    if (enable) begin
      case (state)
        IDLE: if (start) begin
          shreg_nx = nums;
          bcd_nx   = '0;
          ovf_nx   = 1'b0;
          bit_nx   = '0;
          busy_nx  = 1'b1;
          state_nx = CONV;
        end
        CONV: begin
          {ovf_bit, bcd_nx, shreg_nx} = {adj, shreg, 1'b0};
          ovf_nx = overflow | ovf_bit;
          bit_nx = bit_cnt + CW'(1);
          if (bit_cnt == CW'(NUM_W - 1)) begin
            k_nx     = '0;
            lead_nx  = 1'b1;
            state_nx = WRITE;
          end
        end
        WRITE: begin
          if (k == 4'(DIGITS)) begin
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = FIN;
          end else begin
            we_nx   = 1'b1;
            addr_nx = ADDR_W'(BASE_ADDR) + ADDR_W'(k);
            if (overflow)
              dina_nx = DATA_W'(TILE_BASE) + DATA_W'(9);
            else if (LEAD_BLANK && lead && cur == 4'd0 && k != 4'(DIGITS - 1))
              dina_nx = DATA_W'(BLANK_TILE);
            else
              dina_nx = DATA_W'(TILE_BASE) + DATA_W'(cur);
            lead_nx = lead & (cur == 4'd0);
            k_nx    = k + 4'd1;
          end
        end
        // done is visible this cycle; a start here is dropped
        FIN: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bcd      <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      k        <= '0;
      lead     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      we       <= 1'b0;
      addr     <= ADDR_W'(BASE_ADDR);
      dina     <= DATA_W'(TILE_BASE);
    end else begin
      state    <= state_nx;
      bcd      <= bcd_nx;
      shreg    <= shreg_nx;
      bit_cnt  <= bit_nx;
      k        <= k_nx;
      lead     <= lead_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      overflow <= ovf_nx;
      we       <= we_nx;
      addr     <= addr_nx;
      dina     <= dina_nx;
    end
  end
endmodule
